// File: rtl/alarm_pio_pkg.sv
// Shared constants for the alarm-clock button PIO: register addresses and edge-capture modes.
`timescale 1ns/1ps
package alarm_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when a stable-value transition old_v -> new_v matches the capture mode.
  function automatic logic edge_hit(input int edge_type, input logic old_v, input logic new_v);
    case (edge_type)
      EDGE_RISE: return ~old_v & new_v;
      EDGE_FALL: return old_v & ~new_v;
      default:   return old_v ^ new_v;
    endcase
  endfunction

endpackage

// File: rtl/alarm_pio_debounce.sv
// One button bit: 2-flop synchroniser, disagreement counter, debounced stable value
// and a single-cycle edge pulse aligned with the stable update.
`timescale 1ns/1ps
module alarm_pio_debounce
  import alarm_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic edge_evt
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync2_q;
    end else if (sync2_q != stable_q) begin
      // cnt_q counts disagreeing cycles already seen; this cycle is number cnt_q+1.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable   = stable_q;
  assign edge_evt = edge_hit(EDGE_TYPE, stable_q, stable_d);

endmodule

// File: rtl/alarm_button_pio.sv
// Avalon-MM input PIO for the alarm-clock buttons: debounced DATA, IRQ mask,
// sticky write-1-to-clear edge capture and a level interrupt.
`timescale 1ns/1ps
module alarm_button_pio
  import alarm_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alarm_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_deb (
      .clk     (clk),
      .rst     (reset),
      .pin     (in_port[i]),
      .stable  (stable[i]),
      .edge_evt(edge_evt[i])
    );
  end

  always_comb begin
    wr     = chipselect & ~write_n;
    mask_d = mask_q;
    clr    = '0;
    if (wr && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGE) clr = writedata[WIDTH-1:0];
    // A new edge overrides a clear landing on the same bit in the same cycle.
    edge_cap_d = (edge_cap_q & ~clr) | edge_evt;

    // Read mux uses pre-write register state and ignores chipselect.
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = |(edge_cap_q & mask_q);
  assign unused_wdata = ^writedata;

endmodule
